// File: rtl/alu_share_arbiter_if.sv
// Bundle of request, ALU drive and response signals around the shared ALU.
//
// Handshake rule for both channels (req and rsp): a beat transfers on a rising
// clock edge where valid && ready are both high. The source keeps valid and its
// payload stable until the transfer. Ready may be high without valid, and it
// never depends combinationally on the other channel's ready.
interface alu_share_arbiter_if #(
    parameter int WIDTH = 64
);
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [2*WIDTH-1:0] req_a;
    logic [2*WIDTH-1:0] req_b;
    logic [5:0]         req_cntrl;

    logic [WIDTH-1:0]   alu_a;
    logic [WIDTH-1:0]   alu_b;
    logic [2:0]         alu_cntrl;
    logic [WIDTH-1:0]   alu_result;
    logic [3:0]         alu_flags;

    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_id;
    logic [WIDTH-1:0]   rsp_result;
    logic [3:0]         rsp_flags;
    logic               rsp_err;

    // Arbiter side.
    modport slave (
        input  req_valid, req_a, req_b, req_cntrl,
        output req_ready,
        output alu_a, alu_b, alu_cntrl,
        input  alu_result, alu_flags,
        output rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err,
        input  rsp_ready
    );

    // Requesters, ALU instance and response consumer side.
    modport master (
        output req_valid, req_a, req_b, req_cntrl,
        input  req_ready,
        input  alu_a, alu_b, alu_cntrl,
        output alu_result, alu_flags,
        input  rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err,
        output rsp_ready
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one multi-cycle ALU between two requesters.
// Operands are registered onto the ALU, held for EXEC_CYCLES settle cycles,
// then result/flags are captured and held until the consumer takes them.
// dbg_state exposes the FSM: 0 = IDLE, 1 = EXEC, 2 = RESP.
module alu_share_arbiter #(
    parameter int WIDTH       = 64,
    parameter int EXEC_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    alu_share_arbiter_if.slave  bus,
    output logic                busy,
    output logic [1:0]          dbg_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] COUNT_INIT = 4'(EXEC_CYCLES - 1);

    state_t           state_q, state_d;
    logic             rr_last_q, rr_last_d;
    logic [3:0]       count_q, count_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]       alu_cntrl_q, alu_cntrl_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic [3:0]       rsp_flags_q, rsp_flags_d;
    logic             rsp_err_q, rsp_err_d;

    logic [1:0]       grant;
    logic             grant_id;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [2:0]       sel_cntrl;
    logic             sel_illegal;

    // Round-robin grant: only offered in IDLE out of reset; on contention the
    // requester that did not win last time goes first.
    always_comb begin
        grant    = 2'b00;
        grant_id = 1'b0;
        if (state_q == IDLE && reset_n) begin
            case (bus.req_valid)
                2'b01: begin grant = 2'b01; grant_id = 1'b0; end
                2'b10: begin grant = 2'b10; grant_id = 1'b1; end
                2'b11: begin
                    grant_id = ~rr_last_q;
                    grant    = rr_last_q ? 2'b01 : 2'b10;
                end
                default: begin grant = 2'b00; grant_id = 1'b0; end
            endcase
        end
        sel_a       = grant_id ? bus.req_a[2*WIDTH-1:WIDTH] : bus.req_a[WIDTH-1:0];
        sel_b       = grant_id ? bus.req_b[2*WIDTH-1:WIDTH] : bus.req_b[WIDTH-1:0];
        sel_cntrl   = grant_id ? bus.req_cntrl[5:3] : bus.req_cntrl[2:0];
        sel_illegal = (sel_cntrl == 3'b001) || (sel_cntrl == 3'b111);
    end

    // Next-state and datapath loads for IDLE -> EXEC/RESP -> IDLE.
    always_comb begin
        state_d      = state_q;
        rr_last_d    = rr_last_q;
        count_d      = count_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_cntrl_d  = alu_cntrl_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (grant != 2'b00) begin
                    alu_a_d     = sel_a;
                    alu_b_d     = sel_b;
                    alu_cntrl_d = sel_cntrl;
                    rr_last_d   = grant_id;
                    rsp_id_d    = grant_id;
                    if (sel_illegal) begin
                        // No point waiting on the ALU for an undefined opcode.
                        rsp_valid_d  = 1'b1;
                        rsp_err_d    = 1'b1;
                        rsp_result_d = '0;
                        rsp_flags_d  = 4'b0000;
                        state_d      = RESP;
                    end else begin
                        count_d = COUNT_INIT;
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                if (count_q == 4'd0) begin
                    rsp_valid_d  = 1'b1;
                    rsp_err_d    = 1'b0;
                    rsp_result_d = bus.alu_result;
                    rsp_flags_d  = bus.alu_flags;
                    state_d      = RESP;
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            rr_last_q    <= 1'b1;
            count_q      <= 4'd0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_cntrl_q  <= 3'b000;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= 4'b0000;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_last_q    <= rr_last_d;
            count_q      <= count_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_cntrl_q  <= alu_cntrl_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign bus.req_ready  = grant;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_cntrl  = alu_cntrl_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_flags  = rsp_flags_q;
    assign bus.rsp_err    = rsp_err_q;
    assign busy           = (state_q != IDLE);
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a multi-cycle ALU stand-in, a transaction-level
// reference model with an expected-response queue, directed scenarios and a
// randomized phase.
module tb_alu_share_arbiter;
    localparam int W = 64;
    localparam int E = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       busy;
    logic [1:0] dbg_state;

    alu_share_arbiter_if #(.WIDTH(W)) bus ();

    alu_share_arbiter #(.WIDTH(W), .EXEC_CYCLES(E)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .busy     (busy),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_msg(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event not seen within cycle budget (cycle %0d)", name, cyc);
    endtask

    // ALU behaviour: flags = {negative, zero, overflow, carry_out}.
    function automatic void alu_fn(input logic [2:0] c, input logic [W-1:0] a,
                                   input logic [W-1:0] b, output logic [W-1:0] r,
                                   output logic [3:0] f);
        logic [W:0] s;
        logic ov, co;
        s = '0; ov = 1'b0; co = 1'b0;
        case (c)
            3'b000: r = a & b;
            3'b010: begin
                s  = {1'b0, a} + {1'b0, b};
                r  = s[W-1:0];
                co = s[W];
                ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            3'b011: begin
                s  = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
                r  = s[W-1:0];
                co = s[W];
                ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            3'b100: r = a | b;
            3'b101: r = a ^ b;
            3'b110: r = ~(a | b);
            default: r = '0;
        endcase
        f = {r[W-1], (r == '0), ov, co};
    endfunction

    // ---------------- multi-cycle ALU stand-in ----------------
    // Produces the true result only once its inputs have been stable for E
    // cycles; before that it drives the complement, so an early capture shows.
    logic [W-1:0] seen_a = '0, seen_b = '0, p_r;
    logic [2:0]   seen_c = '0;
    logic [3:0]   p_f;
    int           age = 0;
    always @(negedge clk) begin
        if (bus.alu_a !== seen_a || bus.alu_b !== seen_b || bus.alu_cntrl !== seen_c) begin
            age = 1;
            seen_a = bus.alu_a; seen_b = bus.alu_b; seen_c = bus.alu_cntrl;
        end else if (age < 1000) begin
            age++;
        end
        alu_fn(bus.alu_cntrl, bus.alu_a, bus.alu_b, p_r, p_f);
        if (age >= E) begin
            bus.alu_result = p_r;
            bus.alu_flags  = p_f;
        end else begin
            bus.alu_result = ~p_r;
            bus.alu_flags  = ~p_f;
        end
    end

    // ---------------- reference model ----------------
    // Transaction view: idle or owning one operation whose response is due at
    // cycle m_rsp_at and stays pending until rsp_ready is seen.
    function automatic int pick(input logic [1:0] v, input logic last);
        if (v == 2'b01) return 0;
        if (v == 2'b10) return 1;
        if (v == 2'b11) return last ? 0 : 1;
        return -1;
    endfunction

    bit           m_idle = 1'b1;
    logic         m_rr_last = 1'b1;
    int           m_rsp_at = 0;
    int           m_g;
    logic [W-1:0] m_alu_a = '0, m_alu_b = '0, m_r;
    logic [2:0]   m_alu_c = '0;
    logic [3:0]   m_f;
    // entry = {id, err, flags[3:0], result[W-1:0]}
    logic [W+5:0] exp_q[$];
    int           obs_grant_q[$];

    always @(posedge clk) begin
        if (!reset_n) begin
            m_idle = 1'b1; m_rr_last = 1'b1;
            m_alu_a = '0; m_alu_b = '0; m_alu_c = '0;
            exp_q.delete();
        end else if (m_idle) begin
            m_g = pick(bus.req_valid, m_rr_last);
            if (m_g >= 0) begin
                m_alu_a   = (m_g == 1) ? bus.req_a[2*W-1:W] : bus.req_a[W-1:0];
                m_alu_b   = (m_g == 1) ? bus.req_b[2*W-1:W] : bus.req_b[W-1:0];
                m_alu_c   = (m_g == 1) ? bus.req_cntrl[5:3] : bus.req_cntrl[2:0];
                m_rr_last = (m_g == 1);
                m_idle    = 1'b0;
                if (m_alu_c == 3'b001 || m_alu_c == 3'b111) begin
                    m_rsp_at = cyc + 1;
                    exp_q.push_back({(m_g == 1), 1'b1, 4'b0000, {W{1'b0}}});
                end else begin
                    m_rsp_at = cyc + 1 + E;
                    alu_fn(m_alu_c, m_alu_a, m_alu_b, m_r, m_f);
                    exp_q.push_back({(m_g == 1), 1'b0, m_f, m_r});
                end
            end
        end else if (cyc >= m_rsp_at && bus.rsp_ready) begin
            m_idle = 1'b1;
        end
        cyc++;
    end

    // ---------------- per-cycle compare ----------------
    int           c_g;
    logic [1:0]   c_exp_ready;
    logic         c_ev;
    logic [W+5:0] c_e;
    always @(negedge clk) begin
        if (chk_en) begin
            c_exp_ready = 2'b00;
            if (m_idle && reset_n) begin
                c_g = pick(bus.req_valid, m_rr_last);
                if (c_g >= 0) c_exp_ready = (c_g == 1) ? 2'b10 : 2'b01;
            end
            c_ev = !m_idle && (cyc >= m_rsp_at);
            chk("req_ready", W'(bus.req_ready), W'(c_exp_ready));
            chk("busy", W'(busy), W'(!m_idle));
            chk("rsp_valid", W'(bus.rsp_valid), W'(c_ev));
            chk("alu_a", bus.alu_a, m_alu_a);
            chk("alu_b", bus.alu_b, m_alu_b);
            chk("alu_cntrl", W'(bus.alu_cntrl), W'(m_alu_c));
            if (c_ev) begin
                if (exp_q.size() == 0) begin
                    fail_msg("exp_q_empty");
                end else begin
                    c_e = exp_q[0];
                    chk("rsp_id", W'(bus.rsp_id), W'(c_e[W+5]));
                    chk("rsp_err", W'(bus.rsp_err), W'(c_e[W+4]));
                    chk("rsp_flags", W'(bus.rsp_flags), W'(c_e[W+3:W]));
                    chk("rsp_result", bus.rsp_result, c_e[W-1:0]);
                    if (bus.rsp_ready) void'(exp_q.pop_front());
                end
            end
            if (reset_n && (bus.req_valid & bus.req_ready) != 2'b00)
                obs_grant_q.push_back(bus.req_ready[1] ? 1 : 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_req(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [2:0] c);
        logic [2*W-1:0] ta, tb;
        logic [5:0]     tc;
        ta = bus.req_a; tb = bus.req_b; tc = bus.req_cntrl;
        ta[r*W +: W] = a;
        tb[r*W +: W] = b;
        tc[r*3 +: 3] = c;
        bus.req_a = ta; bus.req_b = tb; bus.req_cntrl = tc;
        bus.req_valid[r] = 1'b1;
    endtask

    // Present a request and hold it until granted; returns the grant cycle.
    task automatic go_op(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] c, output int n, output logic [1:0] rdy);
        drive_req(r, a, b, c);
        n = -1;
        rdy = 2'b00;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.req_ready[r]) begin
                n = cyc;
                rdy = bus.req_ready;
                break;
            end
        end
        if (n < 0) fail_msg("grant_timeout");
        @(posedge clk); #1;
        bus.req_valid[r] = 1'b0;
    endtask

    // Wait for rsp_valid; latency is counted from the grant cycle n.
    task automatic wait_rsp(input int n, output int lat, output logic [W+5:0] got);
        lat = -1;
        got = '0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                lat = cyc - n;
                got = {bus.rsp_id, bus.rsp_err, bus.rsp_flags, bus.rsp_result};
                break;
            end
        end
        if (lat < 0) fail_msg("rsp_timeout");
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    int           n, lat, start;
    logic [1:0]   rdy;
    logic [W+5:0] got, held;

    initial begin
        bus.req_valid = 2'b00;
        bus.req_a = '0; bus.req_b = '0; bus.req_cntrl = 6'd0;
        bus.rsp_ready = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        // Reset state.
        chk("rst_busy", W'(busy), '0);
        chk("rst_state", W'(dbg_state), '0);
        chk("rst_rsp_valid", W'(bus.rsp_valid), '0);
        chk("rst_rsp_id", W'(bus.rsp_id), '0);
        chk("rst_rsp_result", bus.rsp_result, '0);
        chk("rst_rsp_flags", W'(bus.rsp_flags), '0);
        chk("rst_rsp_err", W'(bus.rsp_err), '0);
        chk("rst_alu_a", bus.alu_a, '0);
        chk("rst_req_ready", W'(bus.req_ready), '0);
        next_cycle();
        reset_n = 1'b1;
        chk_en = 1'b1;
        bus.rsp_ready = 1'b1;

        // 1: add from requester 0.
        go_op(0, 64'd5, 64'd3, 3'b010, n, rdy);
        chk("t1_ready", W'(rdy), W'(2'b01));
        @(negedge clk);
        chk("t1_alu_a", bus.alu_a, 64'd5);
        wait_rsp(n, lat, got);
        chk("t1_latency", W'(lat), W'(3));
        chk("t1_result", got[W-1:0], 64'd8);
        chk("t1_flags", W'(got[W+3:W]), W'(4'b0000));
        chk("t1_id", W'(got[W+5]), '0);
        chk("t1_err", W'(got[W+4]), '0);
        next_cycle();

        // 2: sub from requester 1.
        go_op(1, 64'd3, 64'd5, 3'b011, n, rdy);
        chk("t2_ready", W'(rdy), W'(2'b10));
        wait_rsp(n, lat, got);
        chk("t2_latency", W'(lat), W'(3));
        chk("t2_result", got[W-1:0], 64'hFFFF_FFFF_FFFF_FFFE);
        chk("t2_flags", W'(got[W+3:W]), W'(4'b1000));
        chk("t2_id", W'(got[W+5]), W'(1));
        next_cycle();

        // 3: both requesters continuously valid -> strict alternation.
        start = obs_grant_q.size();
        drive_req(0, {$urandom, $urandom}, {$urandom, $urandom}, 3'b010);
        drive_req(1, {$urandom, $urandom}, {$urandom, $urandom}, 3'b101);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk); #1;
            if (obs_grant_q.size() >= start + 4) break;
        end
        next_cycle();
        bus.req_valid = 2'b00;
        if (obs_grant_q.size() < start + 4) begin
            fail_msg("t3_grants");
        end else begin
            for (int k = 0; k < 4; k++) chk("t3_grant_order", W'(obs_grant_q[start+k]), W'(k % 2));
        end
        for (int k = 0; k < 50; k++) begin
            @(negedge clk); #1;
            if (!busy) break;
        end
        next_cycle();

        // 4: illegal opcode from requester 1, then a normal request.
        go_op(1, 64'h1234, 64'h55, 3'b111, n, rdy);
        wait_rsp(n, lat, got);
        chk("t4_latency", W'(lat), W'(1));
        chk("t4_err", W'(got[W+4]), W'(1));
        chk("t4_result", got[W-1:0], '0);
        chk("t4_flags", W'(got[W+3:W]), '0);
        chk("t4_id", W'(got[W+5]), W'(1));
        next_cycle();
        go_op(0, 64'd7, 64'd9, 3'b010, n, rdy);
        wait_rsp(n, lat, got);
        chk("t4b_latency", W'(lat), W'(3));
        chk("t4b_result", got[W-1:0], 64'd16);
        chk("t4b_err", W'(got[W+4]), '0);
        next_cycle();

        // 5: consumer stalls for 5 cycles while both requesters wait.
        bus.rsp_ready = 1'b0;
        go_op(0, 64'd10, 64'd4, 3'b011, n, rdy);
        wait_rsp(n, lat, held);
        chk("t5_result", held[W-1:0], 64'd6);
        next_cycle();
        drive_req(0, 64'd1, 64'd1, 3'b010);
        drive_req(1, 64'd100, 64'd1, 3'b010);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t5_hold_rsp", W'({bus.rsp_id, bus.rsp_err, bus.rsp_flags}), W'(held[W+5:W]));
            chk("t5_hold_result", bus.rsp_result, held[W-1:0]);
            chk("t5_hold_ready", W'(bus.req_ready), '0);
            chk("t5_hold_busy", W'(busy), W'(1));
        end
        next_cycle();
        bus.rsp_ready = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("t5_regrant", W'(bus.req_ready), W'(2'b10));
        n = cyc;
        next_cycle();
        bus.req_valid = 2'b00;
        wait_rsp(n, lat, got);
        chk("t5_id", W'(got[W+5]), W'(1));
        chk("t5b_result", got[W-1:0], 64'd101);
        next_cycle();

        // 6: reset while in EXEC drops the operation.
        go_op(0, 64'd1, 64'd2, 3'b010, n, rdy);
        reset_n = 1'b0;
        next_cycle();
        reset_n = 1'b1;
        @(negedge clk);
        chk("t6_busy", W'(busy), '0);
        chk("t6_rsp_valid", W'(bus.rsp_valid), '0);
        chk("t6_alu_a", bus.alu_a, '0);
        chk("t6_alu_b", bus.alu_b, '0);
        chk("t6_alu_cntrl", W'(bus.alu_cntrl), '0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("t6_no_rsp", W'(bus.rsp_valid), '0);
        end
        next_cycle();
        drive_req(0, 64'd20, 64'd22, 3'b010);
        drive_req(1, 64'd1, 64'd1, 3'b000);
        @(negedge clk);
        chk("t6_first_grant", W'(bus.req_ready), W'(2'b01));
        n = cyc;
        next_cycle();
        bus.req_valid = 2'b00;
        wait_rsp(n, lat, got);
        chk("t6_result", got[W-1:0], 64'd42);
        chk("t6_id", W'(got[W+5]), '0);
        next_cycle();

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            reset_n       = ($urandom_range(0, 149) != 0);
            bus.req_valid = 2'($urandom_range(0, 3));
            bus.req_a     = {$urandom, $urandom, $urandom, $urandom};
            bus.req_b     = ($urandom_range(0, 3) == 0) ? bus.req_a
                                                        : {$urandom, $urandom, $urandom, $urandom};
            bus.req_cntrl = 6'($urandom_range(0, 63));
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            next_cycle();
        end
        reset_n = 1'b1;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b1;
        repeat (20) next_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
